// File: rtl/au_pkg.sv
// au_pkg: shared types and default latencies for the arithmetic unit and
// its issue sequencer.
package au_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULT = 2'b10,
    OP_DIV  = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    RESP
  } seq_state_e;

  // AU cycles from restart release until the named result is valid
  localparam int AU_MULT_LAT   = 32;
  localparam int AU_DIV_LAT    = 32;
  localparam int AU_ADDSUB_LAT = 1;

  function automatic int max_lat(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/au_lat_counter.sv
// au_lat_counter: loadable down-counter that flags the final cycle of an
// AU operation (count == 1).
module au_lat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] count;

  // Load on accept, count down while the AU runs; never wraps below zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/au_issue_seq.sv
// au_issue_seq: issue-and-capture sequencer in front of the 32-bit AU.
// Accepts one op over req_*, pulses au_rst_n low for one cycle, holds the
// operands for the op latency, then registers the AU result on rsp_*.
// Optional feature macro: AU_SEQ_DIV0_EN (divide-by-zero shortcut that
// answers without restarting the AU and raises rsp_div0).
import au_pkg::*;

module au_issue_seq #(
  parameter int MULT_LAT   = AU_MULT_LAT,
  parameter int DIV_LAT    = AU_DIV_LAT,
  parameter int ADDSUB_LAT = AU_ADDSUB_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_op,
  output logic [31:0] au_a,
  output logic [31:0] au_b,
  output logic [1:0]  au_op,
  output logic        au_rst_n,
  input  logic [31:0] au_s,
  input  logic [31:0] au_hi,
  input  logic [31:0] au_lo,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_s,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic [1:0]  rsp_op,
  output logic        rsp_zero,
  output logic        rsp_div0
);

  localparam int MAX_LAT = max_lat(MULT_LAT, DIV_LAT, ADDSUB_LAT);
  localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  // A zero latency would leave the counter with no final cycle to detect
  if (MULT_LAT < 1 || DIV_LAT < 1 || ADDSUB_LAT < 1) begin : g_lat_check
    $error("au_issue_seq: AU latencies must be at least 1");
  end

  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] op);
    logic [CNT_W-1:0] l;
    case (op)
      OP_MULT: l = CNT_W'(MULT_LAT);
      OP_DIV:  l = CNT_W'(DIV_LAT);
      default: l = CNT_W'(ADDSUB_LAT);
    endcase
    return l;
  endfunction

  function automatic logic all_zero(input logic [31:0] x, input logic [31:0] y);
    return (x | y) == 32'd0;
  endfunction

  seq_state_e state, state_nxt;
  logic       accept;
  logic       done;
  logic       cnt_last;
  logic       div0_fast;
  logic       div0_take;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  // AU is held in reset by the sequencer reset and restarted in START
  assign au_rst_n  = ~rst && (state != START);

`ifdef AU_SEQ_DIV0_EN
  assign div0_fast = (req_op == OP_DIV) && (req_b == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif
  assign div0_take = accept && div0_fast;

  au_lat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .value (lat_of(req_op)),
    .dec   (state == RUN),
    .last  (cnt_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; done marks the edge that captures the AU result
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (req_valid) state_nxt = div0_fast ? RESP : START;
      START: state_nxt = RUN;
      RUN: begin
        if (cnt_last) begin
          state_nxt = RESP;
          done      = 1'b1;
        end
      end
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/op hold registers: change only on accept, stable through RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      au_a  <= '0;
      au_b  <= '0;
      au_op <= '0;
    end else if (accept) begin
      au_a  <= req_a;
      au_b  <= req_b;
      au_op <= req_op;
    end
  end

  // Result registers: loaded on the final RUN edge or by the div-by-zero shortcut
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_s    <= '0;
      rsp_hi   <= '0;
      rsp_lo   <= '0;
      rsp_op   <= '0;
      rsp_zero <= 1'b0;
    end else if (done) begin
      rsp_op <= au_op;
      if (au_op == OP_MULT || au_op == OP_DIV) begin
        rsp_s    <= '0;
        rsp_hi   <= au_hi;
        rsp_lo   <= au_lo;
        rsp_zero <= all_zero(au_hi, au_lo);
      end else begin
        rsp_s    <= au_s;
        rsp_hi   <= '0;
        rsp_lo   <= '0;
        rsp_zero <= all_zero(au_s, 32'd0);
      end
    end else if (div0_take) begin
      rsp_op   <= req_op;
      rsp_s    <= '0;
      rsp_hi   <= req_a;
      rsp_lo   <= 32'hFFFF_FFFF;
      rsp_zero <= 1'b0;
    end
  end

`ifdef AU_SEQ_DIV0_EN
  // Divide-by-zero flag: set by the shortcut, cleared by any AU completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_div0 <= 1'b0;
    end else if (div0_take) begin
      rsp_div0 <= 1'b1;
    end else if (done) begin
      rsp_div0 <= 1'b0;
    end
  end
`else
  assign rsp_div0 = 1'b0;
`endif

endmodule

// File: tb/tb_au_issue_seq.sv
// tb_au_issue_seq: directed bench for au_issue_seq with a behavioural AU
// model and a queue of expected responses.
module tb_au_issue_seq;
  import au_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_op;
  logic [31:0] au_a, au_b;
  logic [1:0]  au_op;
  logic        au_rst_n;
  logic [31:0] au_s, au_hi, au_lo;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_s, rsp_hi, rsp_lo;
  logic [1:0]  rsp_op;
  logic        rsp_zero, rsp_div0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] s;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  op;
    logic        zero;
    logic        div0;
    int          edge_n;
    int          rstlow;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_a, cur_b;
  logic [1:0]  cur_op;
  int unsigned au_cyc = 0;
  logic [63:0] prod;

  au_issue_seq dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .au_a      (au_a),
    .au_b      (au_b),
    .au_op     (au_op),
    .au_rst_n  (au_rst_n),
    .au_s      (au_s),
    .au_hi     (au_hi),
    .au_lo     (au_lo),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_hi    (rsp_hi),
    .rsp_lo    (rsp_lo),
    .rsp_op    (rsp_op),
    .rsp_zero  (rsp_zero),
    .rsp_div0  (rsp_div0)
  );

  always #5 clk = ~clk;

  // AU model: cycle count since restart release
  always @(posedge clk) begin
    if (!au_rst_n) au_cyc <= 0;
    else if (au_cyc < 1000) au_cyc <= au_cyc + 1;
  end

  // AU model outputs: junk until the op latency has elapsed
  always_comb begin
    au_s  = 32'hBAD0_0001;
    au_hi = 32'hBAD0_0002;
    au_lo = 32'hBAD0_0003;
    prod  = 64'(au_a) * 64'(au_b);
    if (au_rst_n && (au_cyc + 1 >= AU_ADDSUB_LAT)) begin
      if (au_op == OP_ADD) au_s = au_a + au_b;
      if (au_op == OP_SUB) au_s = au_a - au_b;
    end
    if (au_rst_n && (au_cyc + 1 >= AU_MULT_LAT) && au_op == OP_MULT) begin
      au_hi = prod[63:32];
      au_lo = prod[31:0];
    end
    if (au_rst_n && (au_cyc + 1 >= AU_DIV_LAT) && au_op == OP_DIV) begin
      if (au_b == 32'd0) begin
        au_hi = au_a;
        au_lo = 32'hFFFF_FFFF;
      end else begin
        au_hi = au_a % au_b;
        au_lo = au_a / au_b;
      end
    end
  end

  function automatic exp_t exp_of(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] op);
    exp_t        e;
    logic [63:0] p;
    e.s = 0; e.hi = 0; e.lo = 0; e.op = op; e.div0 = 1'b0;
    e.edge_n = 34; e.rstlow = 1;
    p = 64'(a) * 64'(b);
    case (op)
      2'b00: begin e.s = a + b; e.edge_n = 3; end
      2'b01: begin e.s = a - b; e.edge_n = 3; end
      2'b10: begin e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b != 0) begin
          e.hi = a % b;
          e.lo = a / b;
        end else begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
`ifdef AU_SEQ_DIV0_EN
          e.div0 = 1'b1; e.edge_n = 1; e.rstlow = 0;
`endif
        end
      end
    endcase
    e.zero = op[1] ? (e.hi == 0 && e.lo == 0) : (e.s == 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    sb.push_back(exp_of(a, b, op));
    cur_a = a; cur_b = b; cur_op = op;
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int n = 0;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_wait", 64'(n < 200), 64'd1);
    @(posedge clk);
    push_exp(a, b, op);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits for the response, compares it with the queue head, optionally acks
  task automatic wait_rsp(input string tag, input bit ack);
    exp_t e;
    int   i = 0;
    int   low = 0;
    bit   stable = 1'b1;
    while (!rsp_valid && i < 100) begin
      if (!au_rst_n) low++;
      if (au_a !== cur_a || au_b !== cur_b || au_op !== cur_op) stable = 1'b0;
      @(negedge clk);
      i++;
    end
    check({tag, "_timeout"}, 64'(i < 100), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_valid_edge"}, 64'(i + 1), 64'(e.edge_n));
      check({tag, "_au_rst_low_cycles"}, 64'(low), 64'(e.rstlow));
      check({tag, "_operands_stable"}, 64'(stable), 64'd1);
      check({tag, "_s"}, 64'(rsp_s), 64'(e.s));
      check({tag, "_hi"}, 64'(rsp_hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(rsp_lo), 64'(e.lo));
      check({tag, "_op"}, 64'(rsp_op), 64'(e.op));
      check({tag, "_zero"}, 64'(rsp_zero), 64'(e.zero));
      check({tag, "_div0"}, 64'(rsp_div0), 64'(e.div0));
    end
    if (ack) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
      check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    cur_a = '0; cur_b = '0; cur_op = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // reset state
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_s", 64'(rsp_s), 64'd0);
    check("rst_rsp_hi", 64'(rsp_hi), 64'd0);
    check("rst_rsp_lo", 64'(rsp_lo), 64'd0);
    check("rst_rsp_op", 64'(rsp_op), 64'd0);
    check("rst_rsp_zero", 64'(rsp_zero), 64'd0);
    check("rst_rsp_div0", 64'(rsp_div0), 64'd0);
    check("rst_au_a", 64'(au_a), 64'd0);
    check("rst_au_b", 64'(au_b), 64'd0);
    check("rst_au_op", 64'(au_op), 64'd0);
    check("rst_au_rst_n", 64'(au_rst_n), 64'd0);
    rst = 1'b0;
    #1;
    check("release_au_rst_n", 64'(au_rst_n), 64'd1);
    @(negedge clk);

    // main function
    send(32'd5, 32'd7, OP_ADD);               wait_rsp("add_5_7", 1'b1);
    send(32'd9, 32'd9, OP_SUB);               wait_rsp("sub_9_9", 1'b1);
    send(32'd3, 32'd5, OP_SUB);               wait_rsp("sub_3_5", 1'b1);
    send(32'h0001_0000, 32'h0001_0000, OP_MULT); wait_rsp("mult_2p16", 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULT); wait_rsp("mult_max", 1'b1);
    send(32'd100, 32'd7, OP_DIV);             wait_rsp("div_100_7", 1'b1);
    send(32'd42, 32'd0, OP_DIV);              wait_rsp("div_42_0", 1'b1);

    // backpressure with a second request held
    send(32'd1, 32'd2, OP_ADD);
    wait_rsp("bp_first", 1'b0);
    req_a = 32'd10; req_b = 32'd4; req_op = OP_SUB; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
      check("bp_rsp_s_stable", 64'(rsp_s), 64'd3);
      check("bp_req_ready_low", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_ready_after_hs", 64'(req_ready), 64'd1);
    check("bp_valid_after_hs", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    push_exp(32'd10, 32'd4, OP_SUB);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_second_accepted", 64'(req_ready), 64'd0);
    wait_rsp("bp_second", 1'b1);

    // reset in the middle of a MULT, with a request present during reset
    send(32'h1234, 32'h5678, OP_MULT);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    req_a = 32'hAAAA; req_b = 32'd3; req_op = OP_ADD; req_valid = 1'b1;
    #1;
    check("midrst_au_rst_n", 64'(au_rst_n), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    check("postrst_au_a", 64'(au_a), 64'd0);
    check("postrst_au_op", 64'(au_op), 64'd0);
    check("postrst_req_ready", 64'(req_ready), 64'd1);
    check("postrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("postrst_au_rst_n", 64'(au_rst_n), 64'd1);
    sb.delete();
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    check("postrst_no_stale_rsp", 64'(stale), 64'd0);

    send(32'd0, 32'd0, OP_ADD);               wait_rsp("add_after_rst", 1'b1);
    send(32'd0, 32'd9, OP_MULT);              wait_rsp("mult_zero", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/au_issue_seq.md
# au_issue_seq

Issue-and-capture sequencer that sits directly in front of the 32-bit arithmetic unit (add/sub/mult/div). It accepts one operation at a time over a valid/ready request port and restarts the AU with a one-cycle low pulse on the AU's active-low reset. It holds operands and ALUop stable for the op's fixed latency, then registers s/hi/lo with a correctly computed zero flag. The registered result is presented on a valid/ready response port.

## Interface
- MULT_LAT, 32, AU cycles from restart release until mult hi/lo are valid
- DIV_LAT, 32, AU cycles from restart release until div hi/lo are valid
- ADDSUB_LAT, 1, cycles until s is valid
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both high
- req_a, req_b  in  32  operands
- req_op  in  2  00 ADD, 01 SUB, 10 MULT, 11 DIV
- au_a, au_b  out  32  operands to AU
- au_op  out  2  ALUop to AU
- au_rst_n  out  1  AU reset/restart, active low
- au_s, au_hi, au_lo  in  32  AU results
- rsp_valid  out  1  result present
- rsp_ready  in  1  result consumed when both high
- rsp_s, rsp_hi, rsp_lo  out  32  registered results
- rsp_op  out  2  op of this result
- rsp_zero  out  1  result-is-zero flag
- rsp_div0  out  1  divide-by-zero flag; tied 0 without AU_SEQ_DIV0_EN

## Operation
- FSM states: IDLE, START, RUN, RESP.
- IDLE: req_ready=1. On handshake, capture a/b/op into au_a/au_b/au_op, load the counter with the op's latency, go to START.
- START: one cycle, au_rst_n=0, then go to RUN.
- RUN: au_rst_n=1. Counter decrements each cycle. When counter==1, register the outputs on that edge and go to RESP:
  - ADD/SUB: rsp_s=au_s, hi=lo=0, zero=(au_s==0).
  - MULT/DIV: rsp_s=0, hi/lo from AU, zero=(hi==0 && lo==0).
- RESP: rsp_valid=1. On rsp_ready go to IDLE.
- req_ready=0 outside IDLE. A pending req_valid waits and is not dropped.
- au_a/au_b/au_op hold their values from capture until the next accept; no glitching while in RUN.
- rsp_* outputs are stable while rsp_valid=1 and rsp_ready=0.
- DIV convention: hi=remainder, lo=quotient. MULT: {hi,lo}=a*b unsigned.
- Counter width is $clog2(max latency+1). A latency of 0 is illegal: elaborate-time assertion.

## Timing
- Reset (async): state IDLE, req_ready=1, rsp_valid=0, every rsp_* output 0, au_a/au_b/au_op 0, au_rst_n=0 while rst is high, 1 after release.
- Accept at edge E0: START covers cycle E0..E1, rsp_valid rises at E0+LAT+2.
  - ADD/SUB: rsp_valid at E0+3.
  - MULT/DIV default: rsp_valid at E0+34.
- Minimum request spacing is LAT+3 cycles. Response handshake at edge Er gives req_ready=1 from Er.
- rst mid-operation: in-flight op is discarded, no response, AU is held in reset.
- Simultaneous req_valid and rst: rst wins, nothing is captured.

## Configuration
- AU_SEQ_DIV0_EN defined: a DIV with req_b==0 skips START/RUN and goes IDLE→RESP. rsp_valid is high at E0+1 with rsp_hi=req_a, rsp_lo=32'hFFFF_FFFF, rsp_s=0, zero=0, div0=1. The AU is not restarted.
- AU_SEQ_DIV0_EN undefined: DIV by 0 follows the normal path with AU results, and rsp_div0 is constant 0.

## Structure
- Shared package au_pkg holds:
  - aluop_e enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_MULT=2'b10, OP_DIV=2'b11
  - seq_state_e enum
  - default latency localparams shared with the AU top
- One sub-module, au_lat_counter (load, decrement, last flag), parameterised on width.

## Test plan
- ADD 5+7 → rsp_s=12, zero=0, rsp_op=00, rsp_valid at E0+3; au_rst_n low exactly one cycle.
- SUB 9−9 → rsp_s=0, zero=1; SUB 3−5 → rsp_s=32'hFFFF_FFFE, zero=0.
- MULT 32'h0001_0000×32'h0001_0000 → hi=1, lo=0, zero=0, rsp_valid at E0+34; au_a/au_b/au_op stable throughout.
- DIV 100/7 → hi=2, lo=14. With AU_SEQ_DIV0_EN, DIV 42/0 → hi=42, lo=32'hFFFF_FFFF, div0=1 at E0+1. Without the macro, div0 is never set.
- Backpressure: hold rsp_ready=0 for 5 cycles with a second req_valid held → rsp_* stable, req_ready=0. The second op is accepted only after the response handshake.
- Assert rst 10 cycles into a MULT → rsp_valid=0, req_ready=1 immediately after release, no stale response.
